// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a single-port unified memory
// Optional fetch anti-starvation guard enabled by defining ARB_FETCH_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_data
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              access_wr;
  logic              d_req;
  logic              force_fetch;
  logic              take_data;
  logic              take_any;

  assign d_req    = d_rd | d_wr;
  assign take_any = d_req | if_req;
  // A forced fetch only overrides data when fetch is actually waiting.
  assign take_data = d_req & ~(force_fetch & if_req);

`ifdef ARB_FETCH_GUARD_EN
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  logic [RUN_W-1:0] run;

  assign force_fetch = (run == RUN_W'(MAX_DATA_RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= '0;
    end else if (state == S_IDLE && take_any) begin
      if (take_data && if_req) begin
        run <= run + RUN_W'(1);
      end else begin
        run <= '0;
      end
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take_any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      access_wr  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_data <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (take_any) begin
            // Address, data and direction are frozen here; later changes are ignored.
            mem_en     <= 1'b1;
            mem_we     <= take_data & d_wr;
            access_wr  <= take_data & d_wr;
            mem_addr   <= take_data ? d_addr : if_addr;
            mem_wdata  <= take_data ? d_wdata : mem_wdata;
            grant_data <= take_data;
          end
        end
        S_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= CNT_W'(WAIT_CYCLES - 1);
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!access_wr) begin
            if (grant_data) begin
              d_rdata <= mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign if_ack   = (state == S_RESP) & ~grant_data;
  assign d_ack    = (state == S_RESP) & grant_data;
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        d_rd;
  logic        d_wr;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        grant_data;

  int checks = 0;
  int fails  = 0;

  logic [15:0] mem [256];
  logic [15:0] p1;
  logic [15:0] p2;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2), .MAX_DATA_RUN(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_stall(if_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_data(grant_data)
  );

  // Memory model: read data appears two cycles after the strobe cycle, junk otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    p1 <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
    p2 <= p1;
  end
  assign mem_rdata = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int d_acks;
  int i_acks;
  int d_before_i;

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0;
    mem[8'h10] = 16'hABCD;
    mem[8'h30] = 16'h5555;
    mem[8'h40] = 16'h7777;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_grant", grant_data, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_stall", {if_stall, d_stall}, 0);
    if_req = 1'b1;
    #1;
    chk("rst_if_stall_follows", if_stall, 1);
    if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Lone fetch
    for (int c = 0; c <= 5; c++) begin
      cyc_start();
      if (c == 0) begin if_req = 1; if_addr = 8'h10; end
      if (c == 5) if_req = 0;
      @(negedge clk);
      chk($sformatf("fetch_mem_en_c%0d", c), mem_en, (c == 1));
      chk($sformatf("fetch_if_ack_c%0d", c), if_ack, (c == 4));
      chk($sformatf("fetch_d_ack_c%0d", c), d_ack, 0);
      if (c <= 3) chk($sformatf("fetch_if_stall_c%0d", c), if_stall, 1);
      if (c == 1) begin
        chk("fetch_addr", mem_addr, 8'h10);
        chk("fetch_we", mem_we, 0);
        chk("fetch_grant", grant_data, 0);
      end
      if (c == 4) chk("fetch_rdata", if_rdata, 16'hABCD);
    end

    // Store
    for (int c = 0; c <= 5; c++) begin
      cyc_start();
      if (c == 0) begin d_wr = 1; d_addr = 8'h20; d_wdata = 16'h1234; end
      if (c == 2) begin d_addr = 8'h99; d_wdata = 16'hFFFF; end
      if (c == 5) d_wr = 0;
      @(negedge clk);
      chk($sformatf("store_mem_en_c%0d", c), mem_en, (c == 1));
      chk($sformatf("store_d_ack_c%0d", c), d_ack, (c == 4));
      if (c == 1) begin
        chk("store_we", mem_we, 1);
        chk("store_addr", mem_addr, 8'h20);
        chk("store_wdata", mem_wdata, 16'h1234);
        chk("store_grant", grant_data, 1);
      end
      if (c == 4) chk("store_if_ack", if_ack, 0);
    end

    // Load back the stored word; the fetch rdata register must hold its old value
    for (int c = 0; c <= 5; c++) begin
      cyc_start();
      if (c == 0) begin d_rd = 1; d_addr = 8'h20; end
      if (c == 5) d_rd = 0;
      @(negedge clk);
      chk($sformatf("load_d_ack_c%0d", c), d_ack, (c == 4));
      if (c == 4) begin
        chk("load_rdata", d_rdata, 16'h1234);
        chk("load_if_rdata_hold", if_rdata, 16'hABCD);
      end
    end

    // Collision: data first, then fetch
    for (int c = 0; c <= 10; c++) begin
      cyc_start();
      if (c == 0) begin if_req = 1; if_addr = 8'h40; d_rd = 1; d_addr = 8'h30; end
      if (c == 5) d_rd = 0;
      if (c == 10) if_req = 0;
      @(negedge clk);
      chk($sformatf("col_if_stall_c%0d", c), if_stall, (c <= 8));
      chk($sformatf("col_d_ack_c%0d", c), d_ack, (c == 4));
      chk($sformatf("col_if_ack_c%0d", c), if_ack, (c == 9));
      chk($sformatf("col_mem_en_c%0d", c), mem_en, (c == 1 || c == 6));
      if (c >= 1 && c <= 9) chk($sformatf("col_grant_c%0d", c), grant_data, (c <= 5));
      if (c == 4) chk("col_d_rdata", d_rdata, 16'h5555);
      if (c == 9) chk("col_if_rdata", if_rdata, 16'h7777);
    end

    // Reset in the middle of a load; the held request restarts afterwards
    for (int c = 0; c <= 8; c++) begin
      cyc_start();
      if (c == 0) begin d_rd = 1; d_addr = 8'h30; end
      if (c == 2) rst = 1;
      if (c == 3) rst = 0;
      if (c == 8) d_rd = 0;
      @(negedge clk);
      chk($sformatf("rst_mid_d_ack_c%0d", c), d_ack, (c == 7));
      chk($sformatf("rst_mid_mem_en_c%0d", c), mem_en, (c == 1 || c == 4));
      if (c == 3) begin
        chk("rst_mid_grant", grant_data, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        chk("rst_mid_d_stall", d_stall, 1);
      end
      if (c == 7) chk("rst_mid_restart_rdata", d_rdata, 16'h5555);
    end

    // Back-to-back loads with fetch waiting
    do_reset();
    d_acks = 0; i_acks = 0; d_before_i = -1;
    for (int c = 0; c < 60; c++) begin
      cyc_start();
      if (c == 0) begin d_rd = 1; d_addr = 8'h30; if_req = 1; if_addr = 8'h40; end
      @(negedge clk);
      if (d_ack) d_acks++;
      if (if_ack) begin
        if (i_acks == 0) d_before_i = d_acks;
        i_acks++;
      end
    end
    d_rd = 0; if_req = 0;
`ifdef ARB_FETCH_GUARD_EN
    chk("guard_d_acks", d_acks, 10);
    chk("guard_if_acks", i_acks, 2);
    chk("guard_d_before_first_if", d_before_i, 4);
`else
    chk("strict_d_acks", d_acks, 12);
    chk("strict_if_acks", i_acks, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
